// File: rtl/tuser_out_sched.sv
// tuser_out_sched: binds one SDNet output tuple to each outgoing AXIS packet.
// Tuples queue in a small FIFO; the packet FSM gates beats until a tuple exists.
module tuser_out_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             tsch_aclk,
    input  logic             tsch_arst,
    input  logic             tsch_tuple_valid,
    input  logic [127:0]     tsch_tuple_data,
    output logic             tsch_tuple_full,
    input  logic             tsch_avalid,
    input  logic             tsch_aready,
    input  logic             tsch_tlast,
    output logic             tsch_agate,
    output logic [127:0]     tsch_atuser,
    output logic [CNT_W-1:0] tsch_drop_cnt,
    output logic [CNT_W-1:0] tsch_stall_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic [127:0]  hold;
    logic [127:0]  head;

    logic has_entry;
    logic at_cap;
    logic beat;
    logic pop;
    logic push;
    logic drop;
    logic stall;
    logic latch_hold;

    assign head      = mem[rd_ptr];
    assign has_entry = (count != '0);
    assign at_cap    = (count == DEPTH_C);

    // Beat qualification and FIFO/statistics events for this cycle
    always_comb begin
        beat  = tsch_avalid & tsch_aready & tsch_agate;
        pop   = (state == IDLE) & beat;
        push  = tsch_tuple_valid & (~at_cap | pop);
        drop  = tsch_tuple_valid & ~push;
        stall = (state == IDLE) & tsch_avalid & tsch_aready & ~has_entry;
    end

    // Occupancy next value: simultaneous push and pop cancel out
    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Packet FSM state register
    always_ff @(posedge tsch_aclk) begin
        if (tsch_arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Packet FSM next state, gate and tuser selection
    always_comb begin
        state_nxt   = state;
        tsch_agate  = 1'b0;
        tsch_atuser = '0;
        latch_hold  = 1'b0;
        unique case (state)
            IDLE: begin
                tsch_agate = has_entry;
                if (has_entry) begin
                    tsch_atuser = head;
                end
                if (beat && !tsch_tlast) begin
                    latch_hold = 1'b1;
                    state_nxt  = PKT;
                end
            end
            PKT: begin
                tsch_agate  = 1'b1;
                tsch_atuser = hold;
                if (beat && tsch_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tuple storage; contents need no reset since count masks stale data
    always_ff @(posedge tsch_aclk) begin
        if (push) begin
            mem[wr_ptr] <= tsch_tuple_data;
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge tsch_aclk) begin
        if (tsch_arst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            tsch_tuple_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count           <= count_nxt;
            tsch_tuple_full <= (count_nxt == DEPTH_C);
        end
    end

    // Hold register keeps the tuple for the remaining beats of a packet
    always_ff @(posedge tsch_aclk) begin
        if (tsch_arst) begin
            hold <= '0;
        end else if (latch_hold) begin
            hold <= head;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge tsch_aclk) begin
        if (tsch_arst) begin
            tsch_drop_cnt  <= '0;
            tsch_stall_cnt <= '0;
        end else begin
            if (drop && !(&tsch_drop_cnt)) begin
                tsch_drop_cnt <= tsch_drop_cnt + CNT_W'(1);
            end
            if (stall && !(&tsch_stall_cnt)) begin
                tsch_stall_cnt <= tsch_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
